// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detected push, FWFT valid/ready pop,
// sticky overrun. Define UART_RX_FIFO_LEVEL_EN to add LEVEL/AFULL outputs.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
`ifdef UART_RX_FIFO_LEVEL_EN
  , parameter int AFULL_THR = DEPTH - 2
`endif
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 WR_DRDY,
  input  logic [DATA_BITS-1:0] WR_DI,
  output logic                 RD_VALID,
  input  logic                 RD_READY,
  output logic [DATA_BITS-1:0] RD_DO,
  output logic                 FULL,
  output logic                 OVERRUN,
  input  logic                 OVR_CLR
`ifdef UART_RX_FIFO_LEVEL_EN
  , output logic [$clog2(DEPTH):0] LEVEL
  , output logic                   AFULL
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic                 drdy_q, push_req, push, pop;
  logic                 nx_empty, nx_full;

  // A push that meets a full FIFO still lands if the same edge pops.
  assign push_req = WR_DRDY & ~drdy_q;
  assign pop      = RD_VALID & RD_READY;
  assign push     = push_req & (~FULL | pop);

  assign wr_nx    = wr_ptr + PW'(push);
  assign rd_nx    = rd_ptr + PW'(pop);
  assign nx_empty = (wr_nx == rd_nx);
  assign nx_full  = (wr_nx[AW] != rd_nx[AW]) && (wr_nx[AW-1:0] == rd_nx[AW-1:0]);

`ifdef UART_RX_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AFULL_THR_W = PW'(AFULL_THR);
  logic [PW-1:0] level_nx;
  assign level_nx = wr_nx - rd_nx;
`endif

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drdy_q   <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DO    <= '0;
      FULL     <= 1'b0;
      OVERRUN  <= 1'b0;
`ifdef UART_RX_FIFO_LEVEL_EN
      LEVEL    <= '0;
      AFULL    <= 1'b0;
`endif
    end else begin
      drdy_q   <= WR_DRDY;
      wr_ptr   <= wr_nx;
      rd_ptr   <= rd_nx;
      RD_VALID <= ~nx_empty;
      FULL     <= nx_full;
      if (push)
        mem[wr_ptr[AW-1:0]] <= WR_DI;
      // Head register bypasses the RAM when the new head is being written this edge.
      if (!nx_empty)
        RD_DO <= (push && (rd_nx == wr_ptr)) ? WR_DI : mem[rd_nx[AW-1:0]];
      if (push_req && FULL && !pop)
        OVERRUN <= 1'b1;
      else if (OVR_CLR)
        OVERRUN <= 1'b0;
`ifdef UART_RX_FIFO_LEVEL_EN
      LEVEL    <= level_nx;
      AFULL    <= (level_nx >= AFULL_THR_W);
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DB = 8;
  localparam int D  = 8;

  logic          CLK = 1'b0, NRST = 1'b0, WR_DRDY = 1'b0, RD_READY = 1'b0, OVR_CLR = 1'b0;
  logic [DB-1:0] WR_DI = '0;
  logic          RD_VALID, FULL, OVERRUN;
  logic [DB-1:0] RD_DO;

  uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(D)) dut (
    .CLK(CLK), .NRST(NRST), .WR_DRDY(WR_DRDY), .WR_DI(WR_DI),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DO(RD_DO),
    .FULL(FULL), .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] q[$];
  bit m_prev = 1'b0;
  bit m_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check 1 time unit later.
  task automatic step(input bit rst_n, input bit drdy, input logic [DB-1:0] di,
                      input bit rdy, input bit clr);
    bit rst_now, pr, pop;
    @(negedge CLK);
    NRST = rst_n; WR_DRDY = drdy; WR_DI = di; RD_READY = rdy; OVR_CLR = clr;
    @(posedge CLK);
    rst_now = !rst_n;
    if (rst_now) begin
      q.delete(); m_prev = 1'b0; m_ovr = 1'b0;
    end else begin
      pr  = drdy && !m_prev;
      pop = (q.size() > 0) && rdy;
      if (pop) void'(q.pop_front());
      if (pr && q.size() >= D) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (pr && q.size() < D) q.push_back(di);
      m_prev = drdy;
    end
    #1;
    chk("rd_valid", {31'b0, RD_VALID}, {31'b0, q.size() > 0});
    chk("full",     {31'b0, FULL},     {31'b0, q.size() == D});
    chk("overrun",  {31'b0, OVERRUN},  {31'b0, m_ovr});
    if (rst_now)       chk("rd_do_reset", {24'b0, RD_DO}, 32'h0);
    else if (q.size()) chk("rd_do",       {24'b0, RD_DO}, {24'b0, q[0]});
  endtask

  task automatic push_pulse(input logic [DB-1:0] v, input bit rdy);
    step(1, 1, v, rdy, 0);
    step(1, 0, v, 0, 0);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) step(1, 0, 8'h00, 1, 0);
    chk("drained", {31'b0, RD_VALID}, 32'h0);
  endtask

  initial begin
    logic [DB-1:0] di;
    bit drdy;
    // 1: reset, single push, FWFT
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'hA5, 0, 0);
    chk("t1_head", {24'b0, RD_DO}, 32'hA5);
    step(1, 0, 8'hA5, 0, 0);
    drain(4);
    // 2: level held high yields one push
    for (int i = 0; i < 5; i++) step(1, 1, 8'h3C, 0, 0);
    step(1, 0, 8'h3C, 0, 0);
    chk("t2_count", q.size(), 1);
    step(1, 0, 8'h00, 1, 0);
    chk("t2_empty", {31'b0, RD_VALID}, 32'h0);
    // 3: fill, then overrun drops 8'hFF
    for (int i = 1; i <= D; i++) push_pulse(DB'(i), 0);
    push_pulse(8'hFF, 0);
    chk("t3_ovr", {31'b0, OVERRUN}, 32'h1);
    drain(12);
    step(1, 0, 8'h00, 0, 1);
    chk("t3_clr", {31'b0, OVERRUN}, 32'h0);
    // 4: full plus simultaneous push/pop
    for (int i = 1; i <= D; i++) push_pulse(DB'(i), 0);
    step(1, 1, 8'hFF, 1, 0);
    chk("t4_no_ovr", {31'b0, OVERRUN}, 32'h0);
    chk("t4_tail", {24'b0, q[$]}, 32'hFF);
    step(1, 0, 8'hFF, 0, 0);
    drain(12);
    // 5: interleaved traffic across pointer wrap
    for (int i = 0; i < 24; i++) step(1, (i % 2) == 0, DB'(8'h40 + i / 2), (i % 3) != 0, 0);
    drain(16);
    // 6: reset with entries stored, then overrun and clear
    for (int i = 0; i < 3; i++) push_pulse(DB'(8'h70 + i), 0);
    step(0, 0, 8'h00, 0, 0);
    chk("t6_rst_valid", {31'b0, RD_VALID}, 32'h0);
    for (int i = 0; i <= D; i++) push_pulse(DB'(8'h90 + i), 0);
    step(1, 1, 8'hEE, 0, 1);
    chk("t6_set_wins", {31'b0, OVERRUN}, 32'h1);
    step(1, 0, 8'h00, 0, 1);
    chk("t6_cleared", {31'b0, OVERRUN}, 32'h0);
    drain(12);
    // random traffic
    drdy = 1'b0; di = '0;
    for (int i = 0; i < 600; i++) begin
      if (!drdy) di = DB'($urandom);
      drdy = ($urandom_range(0, 2) == 0) ? ~drdy : drdy;
      step(($urandom_range(0, 199) != 0), drdy, di, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0);
    end
    drain(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
